// File: rtl/lsu_pkg.sv
// Shared address map, load-size/state enums and lane helpers for the MMIO load/store unit.
package lsu_pkg;

  localparam logic [31:0] DMEM_BASE = 32'h0000_2000;
  localparam logic [31:0] LEDR_ADDR = 32'h0000_7000;
  localparam logic [31:0] LEDG_ADDR = 32'h0000_7010;
  localparam logic [31:0] SEG7_BASE = 32'h0000_7020;
  localparam logic [31:0] LCD_ADDR  = 32'h0000_7030;
  localparam logic [31:0] SW_ADDR   = 32'h0000_7800;
  localparam logic [31:0] BTN_ADDR  = 32'h0000_7810;
  localparam logic [31:0] EDGE_ADDR = 32'h0000_7814;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10,
    RSVD = 2'b11
  } ld_size_e;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } lsu_state_e;

  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    strb_mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

  function automatic logic [31:0] ld_extend(input logic [31:0] word, input logic [1:0] off,
                                            input ld_size_e size, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[8*off +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      BYTE:    ld_extend = {{24{~uns & b[7]}}, b};
      HALF:    ld_extend = {{16{~uns & h[15]}}, h};
      default: ld_extend = word;
    endcase
  endfunction

endpackage

// File: rtl/hex7seg_dec.sv
// Hex nibble to active-low 7-segment pattern, segment order {g,f,e,d,c,b,a}.
module hex7seg_dec (
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = 7'b1111111;
    case (i_nib)
      4'h0: o_seg = 7'b1000000;
      4'h1: o_seg = 7'b1111001;
      4'h2: o_seg = 7'b0100100;
      4'h3: o_seg = 7'b0110000;
      4'h4: o_seg = 7'b0011001;
      4'h5: o_seg = 7'b0010010;
      4'h6: o_seg = 7'b0000010;
      4'h7: o_seg = 7'b1111000;
      4'h8: o_seg = 7'b0000000;
      4'h9: o_seg = 7'b0010000;
      4'hA: o_seg = 7'b0001000;
      4'hB: o_seg = 7'b0000011;
      4'hC: o_seg = 7'b1000110;
      4'hD: o_seg = 7'b0100001;
      4'hE: o_seg = 7'b0000110;
      4'hF: o_seg = 7'b0001110;
      default: o_seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/lsu_mmio_v2.sv
// Valid/ready load/store unit: sized data memory, board I/O registers, synchronised inputs,
// W1C button edge capture and an N-digit hex display.
module lsu_mmio_v2 #(
  parameter int unsigned DMEM_WORDS = 2048,
  parameter int unsigned NUM_HEX    = 8,
  parameter int unsigned SW_W       = 32,
  parameter int unsigned BTN_W      = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_req_vld,
  output logic                 o_req_rdy,
  input  logic [31:0]          i_lsu_addr,
  input  logic                 i_lsu_wren,
  input  logic [31:0]          i_st_data,
  input  logic [3:0]           i_st_strb,
  input  logic [1:0]           i_ld_size,
  input  logic                 i_ld_unsigned,
  output logic                 o_rsp_vld,
  input  logic                 i_rsp_rdy,
  output logic [31:0]          o_ld_data,
  output logic                 o_rsp_err,
  input  logic [SW_W-1:0]      i_io_sw,
  input  logic [BTN_W-1:0]     i_io_btn,
  output logic [31:0]          o_io_ledr,
  output logic [31:0]          o_io_ledg,
  output logic [31:0]          o_io_lcd,
  output logic [7*NUM_HEX-1:0] o_io_hex
);
  import lsu_pkg::*;

  localparam int unsigned AW       = $clog2(DMEM_WORDS);
  localparam int unsigned SEG_N    = NUM_HEX / 4;
  localparam logic [31:0] DMEM_END = DMEM_BASE + 32'(4 * DMEM_WORDS);

  lsu_state_e       r_state, w_state_nx;
  logic [31:0]      r_mem [DMEM_WORDS];
  logic [31:0]      r_dmem_rd, r_io_rd, r_ledr, r_ledg, r_lcd;
  logic [31:0]      r_seg [SEG_N];
  logic [SW_W-1:0]  r_sw_s1, r_sw_s2;
  logic [BTN_W-1:0] r_btn_s1, r_btn_s2, r_btn_prev, r_edge;
  logic             r_err, r_wren, r_uns, r_is_dmem;
  logic [1:0]       r_off;
  ld_size_e         r_size;

  logic             w_accept, w_err, w_st, w_misalign, w_mapped;
  logic             w_is_dmem, w_is_ledr, w_is_ledg, w_is_lcd, w_is_sw, w_is_btn, w_is_edge, w_is_seg;
  logic [AW-1:0]    w_dmem_idx;
  logic [29:0]      w_seg_off;
  logic [31:0]      w_mask, w_st_bits, w_io_rd;
  logic [BTN_W-1:0] w_rise, w_clr;
  ld_size_e         w_size;

  assign o_req_rdy = (r_state == IDLE) || i_rsp_rdy;
  assign w_accept  = i_req_vld && o_req_rdy;
  assign o_rsp_vld = (r_state == RESP);
  assign w_size    = ld_size_e'(i_ld_size);
  assign w_mask    = strb_mask(i_st_strb);
  assign w_st_bits = i_st_data & w_mask;

  // Register decode is word-granular; the low address bits only matter for alignment.
  assign w_is_dmem  = (i_lsu_addr >= DMEM_BASE) && (i_lsu_addr < DMEM_END);
  assign w_dmem_idx = i_lsu_addr[AW+1:2] - DMEM_BASE[AW+1:2];
  assign w_is_ledr  = (i_lsu_addr[31:2] == LEDR_ADDR[31:2]);
  assign w_is_ledg  = (i_lsu_addr[31:2] == LEDG_ADDR[31:2]);
  assign w_is_lcd   = (i_lsu_addr[31:2] == LCD_ADDR[31:2]);
  assign w_is_sw    = (i_lsu_addr[31:2] == SW_ADDR[31:2]);
  assign w_is_btn   = (i_lsu_addr[31:2] == BTN_ADDR[31:2]);
  assign w_is_edge  = (i_lsu_addr[31:2] == EDGE_ADDR[31:2]);
  assign w_seg_off  = i_lsu_addr[31:2] - SEG7_BASE[31:2];
  assign w_is_seg   = (w_seg_off < 30'(SEG_N)) && !w_is_lcd;

  assign w_mapped   = w_is_dmem || w_is_ledr || w_is_ledg || w_is_lcd || w_is_sw ||
                      w_is_btn || w_is_edge || w_is_seg;
  assign w_misalign = (w_size == RSVD) || ((w_size == HALF) && i_lsu_addr[0]) ||
                      ((w_size == WORD) && (i_lsu_addr[1:0] != 2'b00));
  assign w_err      = i_lsu_wren ? (!w_mapped || w_is_sw || w_is_btn) : (!w_mapped || w_misalign);
  assign w_st       = w_accept && i_lsu_wren && !w_err && !i_rst;

  assign w_rise = r_btn_s2 & ~r_btn_prev;
  assign w_clr  = (w_st && w_is_edge) ? (i_st_data[BTN_W-1:0] & w_mask[BTN_W-1:0]) : '0;

  always_comb begin
    w_io_rd = '0;
    if (w_is_ledr)      w_io_rd = r_ledr;
    else if (w_is_ledg) w_io_rd = r_ledg;
    else if (w_is_lcd)  w_io_rd = r_lcd;
    else if (w_is_sw)   w_io_rd = 32'(r_sw_s2);
    else if (w_is_btn)  w_io_rd = 32'(r_btn_s2);
    else if (w_is_edge) w_io_rd = 32'(r_edge);
    else if (w_is_seg) begin
      for (int unsigned i = 0; i < SEG_N; i++)
        if (w_seg_off == 30'(i)) w_io_rd = r_seg[i];
    end
  end

  always_comb begin
    w_state_nx = r_state;
    if (w_accept)                        w_state_nx = RESP;
    else if (r_state == RESP && i_rsp_rdy) w_state_nx = IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (w_st && w_is_dmem)
      for (int unsigned b = 0; b < 4; b++)
        if (i_st_strb[b]) r_mem[w_dmem_idx][8*b +: 8] <= i_st_data[8*b +: 8];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_dmem_rd  <= '0;
      r_io_rd    <= '0;
      r_ledr     <= '0;
      r_ledg     <= '0;
      r_lcd      <= '0;
      r_sw_s1    <= '0;
      r_sw_s2    <= '0;
      r_btn_s1   <= '0;
      r_btn_s2   <= '0;
      r_btn_prev <= '0;
      r_edge     <= '0;
      r_err      <= 1'b0;
      r_wren     <= 1'b0;
      r_uns      <= 1'b0;
      r_is_dmem  <= 1'b0;
      r_off      <= '0;
      r_size     <= BYTE;
      for (int unsigned i = 0; i < SEG_N; i++) r_seg[i] <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_sw_s1    <= i_io_sw;
      r_sw_s2    <= r_sw_s1;
      r_btn_s1   <= i_io_btn;
      r_btn_s2   <= r_btn_s1;
      r_btn_prev <= r_btn_s2;
      // Clear first, then OR in new edges so a coincident rise survives the W1C.
      r_edge     <= (r_edge & ~w_clr) | w_rise;
      if (w_st) begin
        if (w_is_ledr) r_ledr <= (r_ledr & ~w_mask) | w_st_bits;
        if (w_is_ledg) r_ledg <= (r_ledg & ~w_mask) | w_st_bits;
        if (w_is_lcd)  r_lcd  <= (r_lcd & ~w_mask) | w_st_bits;
        for (int unsigned i = 0; i < SEG_N; i++)
          if (w_is_seg && w_seg_off == 30'(i)) r_seg[i] <= (r_seg[i] & ~w_mask) | w_st_bits;
      end
      if (w_accept) begin
        r_err     <= w_err;
        r_wren    <= i_lsu_wren;
        r_uns     <= i_ld_unsigned;
        r_size    <= w_size;
        r_off     <= i_lsu_addr[1:0];
        r_is_dmem <= w_is_dmem;
        r_io_rd   <= w_io_rd;
        if (!i_lsu_wren) r_dmem_rd <= r_mem[w_dmem_idx];
      end
    end
  end

  assign o_rsp_err = r_err;
  assign o_ld_data = (r_err || r_wren) ? '0 :
                     ld_extend(r_is_dmem ? r_dmem_rd : r_io_rd, r_off, r_size, r_uns);
  assign o_io_ledr = r_ledr;
  assign o_io_ledg = r_ledg;
  assign o_io_lcd  = r_lcd;

  for (genvar k = 0; k < NUM_HEX; k++) begin : g_hex
    hex7seg_dec u_dec (
      .i_nib (r_seg[k/4][8*(k%4) +: 4]),
      .o_seg (o_io_hex[7*k +: 7])
    );
  end

endmodule

// File: tb/tb_lsu_mmio_v2.sv
// Scoreboard bench: a behavioural model predicts every response and register image.
module tb_lsu_mmio_v2;
  localparam int DMEM_WORDS = 2048;
  localparam int NUM_HEX    = 8;
  localparam int SW_W       = 32;
  localparam int BTN_W      = 4;
  localparam int SEG_N      = NUM_HEX / 4;

  logic clk = 1'b0;
  logic rst, req_vld, req_rdy, wren, ld_uns, rsp_vld, rsp_rdy, rsp_err;
  logic [31:0] addr, st_data, ld_data, ledr, ledg, lcd;
  logic [3:0]  st_strb;
  logic [1:0]  ld_size;
  logic [SW_W-1:0]  sw;
  logic [BTN_W-1:0] btn;
  logic [7*NUM_HEX-1:0] hex;

  always #5 clk = ~clk;

  lsu_mmio_v2 #(.DMEM_WORDS(DMEM_WORDS), .NUM_HEX(NUM_HEX), .SW_W(SW_W), .BTN_W(BTN_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_vld(req_vld), .o_req_rdy(req_rdy),
    .i_lsu_addr(addr), .i_lsu_wren(wren), .i_st_data(st_data), .i_st_strb(st_strb),
    .i_ld_size(ld_size), .i_ld_unsigned(ld_uns), .o_rsp_vld(rsp_vld), .i_rsp_rdy(rsp_rdy),
    .o_ld_data(ld_data), .o_rsp_err(rsp_err), .i_io_sw(sw), .i_io_btn(btn),
    .o_io_ledr(ledr), .o_io_ledg(ledg), .o_io_lcd(lcd), .o_io_hex(hex)
  );

  typedef struct packed { logic [31:0] data; logic err; } rsp_t;
  typedef enum int { K_NONE, K_DMEM, K_LEDR, K_LEDG, K_SEG, K_LCD, K_SW, K_BTN, K_EDGE } kind_e;

  rsp_t exp_q[$];
  int   vectors = 0, miscompares = 0;

  logic [31:0]      m_mem [int];
  logic [31:0]      m_ledr, m_ledg, m_lcd;
  logic [31:0]      m_seg [SEG_N];
  logic [BTN_W-1:0] m_edge, bt_h1, bt_h2, bt_h3;
  logic [SW_W-1:0]  sw_h1, sw_h2;
  bit               m_pending, m_acc;
  int               known[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000; 4'h1: return 7'b1111001; 4'h2: return 7'b0100100;
      4'h3: return 7'b0110000; 4'h4: return 7'b0011001; 4'h5: return 7'b0010010;
      4'h6: return 7'b0000010; 4'h7: return 7'b1111000; 4'h8: return 7'b0000000;
      4'h9: return 7'b0010000; 4'hA: return 7'b0001000; 4'hB: return 7'b0000011;
      4'hC: return 7'b1000110; 4'hD: return 7'b0100001; 4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  function automatic void classify(input logic [31:0] a, output kind_e k, output int idx);
    logic [31:0] wa;
    wa  = a & 32'hFFFF_FFFC;
    idx = 0;
    k   = K_NONE;
    if (wa >= 32'h2000 && wa < 32'h2000 + 4 * DMEM_WORDS) begin k = K_DMEM; idx = int'((wa - 32'h2000) / 4); end
    else if (wa == 32'h7000) k = K_LEDR;
    else if (wa == 32'h7010) k = K_LEDG;
    else if (wa == 32'h7030) k = K_LCD;
    else if (wa == 32'h7800) k = K_SW;
    else if (wa == 32'h7810) k = K_BTN;
    else if (wa == 32'h7814) k = K_EDGE;
    else if (wa >= 32'h7020 && wa < 32'h7020 + 4 * SEG_N) begin k = K_SEG; idx = int'((wa - 32'h7020) / 4); end
  endfunction

  task automatic model_step();
    kind_e k; int idx; bit err;
    logic [31:0] m, rd, v;
    logic [BTN_W-1:0] rise, clr;
    m_acc = 0;
    if (rst) begin
      m_ledr = 0; m_ledg = 0; m_lcd = 0; m_edge = 0; m_pending = 0;
      for (int i = 0; i < SEG_N; i++) m_seg[i] = 0;
      bt_h1 = 0; bt_h2 = 0; bt_h3 = 0; sw_h1 = 0; sw_h2 = 0;
      exp_q.delete();
      return;
    end
    rise = bt_h2 & ~bt_h3;
    clr  = 0;
    if (req_vld && (!m_pending || rsp_rdy)) begin
      m_acc = 1;
      classify(addr, k, idx);
      for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{st_strb[b]}};
      if (wren) begin
        err = (k == K_NONE || k == K_SW || k == K_BTN);
        if (!err) case (k)
          K_DMEM: m_mem[idx] = (m_mem[idx] & ~m) | (st_data & m);
          K_LEDR: m_ledr = (m_ledr & ~m) | (st_data & m);
          K_LEDG: m_ledg = (m_ledg & ~m) | (st_data & m);
          K_LCD:  m_lcd  = (m_lcd & ~m) | (st_data & m);
          K_SEG:  m_seg[idx] = (m_seg[idx] & ~m) | (st_data & m);
          K_EDGE: clr = st_data[BTN_W-1:0] & m[BTN_W-1:0];
          default: ;
        endcase
        exp_q.push_back('{data: 32'h0, err: err});
      end else begin
        err = (k == K_NONE) || (ld_size == 2'd3) || (ld_size == 2'd1 && addr[0]) ||
              (ld_size == 2'd2 && addr[1:0] != 2'd0);
        case (k)
          K_DMEM: rd = m_mem.exists(idx) ? m_mem[idx] : 32'h0;
          K_LEDR: rd = m_ledr;  K_LEDG: rd = m_ledg;  K_LCD: rd = m_lcd;
          K_SEG:  rd = m_seg[idx];
          K_SW:   rd = 32'(sw_h2);
          K_BTN:  rd = 32'(bt_h2);
          K_EDGE: rd = 32'(m_edge);
          default: rd = 0;
        endcase
        v = rd >> (8 * addr[1:0]);
        if (ld_size == 2'd0) begin v = v & 32'hFF;   if (!ld_uns && v >= 32'h80)   v = v | 32'hFFFF_FF00; end
        if (ld_size == 2'd1) begin v = v & 32'hFFFF; if (!ld_uns && v >= 32'h8000) v = v | 32'hFFFF_0000; end
        exp_q.push_back('{data: err ? 32'h0 : v, err: err});
      end
      m_pending = 1;
    end else if (m_pending && rsp_rdy) m_pending = 0;
    m_edge = (m_edge & ~clr) | rise;
    bt_h3 = bt_h2; bt_h2 = bt_h1; bt_h1 = btn;
    sw_h2 = sw_h1; sw_h1 = sw;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Monitor: retire on the DUT handshake, compare the presented response with the queue head.
  initial begin
    bit seen_vld;
    rsp_t e;
    logic [7*NUM_HEX-1:0] eh;
    seen_vld = 0;
    forever begin
      @(posedge clk);
      if (!rst && seen_vld && rsp_rdy && exp_q.size() > 0) void'(exp_q.pop_front());
      #2;
      seen_vld = rsp_vld;
      check("rsp_vld", rsp_vld, m_pending);
      check("req_rdy", req_rdy, !m_pending || rsp_rdy);
      if (rsp_vld) begin
        if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
        else begin
          e = exp_q[0];
          check("rsp_data", ld_data, e.data);
          check("rsp_err", rsp_err, e.err);
        end
      end
      for (int k = 0; k < NUM_HEX; k++) eh[7*k +: 7] = hex7(m_seg[k/4][8*(k%4) +: 4]);
      check("ledr", ledr, m_ledr);
      check("ledg", ledg, m_ledg);
      check("lcd", lcd, m_lcd);
      check("hex", hex, eh);
    end
  end

  task automatic do_req(input logic [31:0] a, input bit wr, input logic [31:0] d,
                        input logic [3:0] s, input logic [1:0] sz, input bit u);
    bit got;
    @(negedge clk);
    rsp_rdy = 1; req_vld = 1; addr = a; wren = wr; st_data = d; st_strb = s; ld_size = sz; ld_uns = u;
    got = 0;
    for (int n = 0; n < 64 && !got; n++) begin
      @(posedge clk); #1;
      got = m_acc;
    end
    if (!got) check("accept_timeout", 0, 1);
  endtask

  task automatic ld_chk(input string name, input logic [31:0] a, input logic [1:0] sz,
                        input bit u, input logic [31:0] ed, input bit ee);
    do_req(a, 0, 0, 0, sz, u);
    check(name, {ld_data, 31'b0, rsp_err}, {ed, 31'b0, ee});
  endtask

  task automatic idle();
    @(negedge clk);
    req_vld = 0;
  endtask

  initial begin
    int issued, guard, pick;
    logic [31:0] a;
    rst = 1; req_vld = 0; addr = 0; wren = 0; st_data = 0; st_strb = 0; ld_size = 0;
    ld_uns = 0; rsp_rdy = 1; sw = 0; btn = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    for (int i = 0; i < 16; i++) known.push_back(i);
    known.push_back(DMEM_WORDS - 1);
    foreach (known[i]) do_req(32'h2000 + 4 * known[i], 1, $urandom, 4'hF, 2'd2, 0);

    do_req(32'h2004, 1, 32'h8899_AABB, 4'hF, 2'd2, 0);
    ld_chk("lb_2005", 32'h2005, 2'd0, 0, 32'hFFFF_FFAA, 0);
    ld_chk("lbu_2005", 32'h2005, 2'd0, 1, 32'h0000_00AA, 0);
    ld_chk("lh_2006", 32'h2006, 2'd1, 0, 32'hFFFF_8899, 0);
    ld_chk("lw_misalign", 32'h2002, 2'd2, 0, 32'h0, 1);
    ld_chk("lh_misalign", 32'h2001, 2'd1, 0, 32'h0, 1);
    ld_chk("ld_rsvd", 32'h2004, 2'd3, 0, 32'h0, 1);
    ld_chk("lw_2004", 32'h2004, 2'd2, 0, 32'h8899_AABB, 0);

    @(negedge clk);
    rsp_rdy = 0; addr = 32'h2000; wren = 0; ld_size = 2'd2;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      check("hold_stable", {rsp_vld, req_rdy, ld_data}, {1'b1, 1'b0, 32'h8899_AABB});
    end
    do_req(32'h2000, 0, 0, 0, 2'd2, 0);

    do_req(32'h7020, 1, 32'h0000_0A05, 4'b0011, 2'd2, 0);
    idle();
    check("hex_5A", hex, {{6{7'b1000000}}, 7'b0001000, 7'b0010010});

    btn = 4'b0100;
    repeat (5) @(negedge clk);
    btn = 0;
    repeat (4) @(negedge clk);
    ld_chk("edge_set", 32'h7814, 2'd2, 0, 32'h4, 0);
    do_req(32'h7814, 1, 32'h4, 4'hF, 2'd2, 0);
    ld_chk("edge_clr", 32'h7814, 2'd2, 0, 32'h0, 0);
    @(negedge clk);
    req_vld = 0; btn = 4'b0100;
    @(posedge clk); @(posedge clk);
    do_req(32'h7814, 1, 32'h4, 4'hF, 2'd2, 0);
    ld_chk("edge_set_wins", 32'h7814, 2'd2, 0, 32'h4, 0);
    btn = 0;

    do_req(32'h7000, 1, 32'hCAFE_F00D, 4'b1010, 2'd2, 0);
    do_req(32'h7800, 1, 32'hFFFF_FFFF, 4'hF, 2'd2, 0);
    check("st_ro_err", rsp_err, 1);
    ld_chk("ld_unmapped", 32'h5000, 2'd2, 0, 32'h0, 1);
    ld_chk("ld_dmem_end", 32'h2000 + 4 * DMEM_WORDS, 2'd2, 0, 32'h0, 1);
    ld_chk("ledr_rd", 32'h7000, 2'd2, 0, 32'hCA00_F000, 0);

    do_req(32'h2000, 0, 0, 0, 2'd2, 0);
    @(negedge clk);
    rsp_rdy = 0; req_vld = 0;
    @(negedge clk);
    rst = 1; rsp_rdy = 1; req_vld = 1; addr = 32'h7010; wren = 1; st_data = 32'h1234_5678; st_strb = 4'hF;
    @(negedge clk);
    rst = 0; req_vld = 0;
    check("rst_drop", {rsp_vld, req_rdy, ledg, ledr}, {1'b0, 1'b1, 32'h0, 32'h0});

    issued = 0;
    guard = 0;
    while (issued < 400 && guard < 20000) begin
      @(negedge clk);
      guard++;
      rsp_rdy = ($urandom_range(0, 3) != 0);
      sw = $urandom;
      if ($urandom_range(0, 7) == 0) btn = BTN_W'($urandom);
      if (req_vld && !m_acc) continue;
      if (req_vld) issued++;
      req_vld = ($urandom_range(0, 4) != 0);
      pick = $urandom_range(0, 11);
      case (pick)
        0, 1, 2: a = 32'h2000 + 4 * known[$urandom_range(0, known.size() - 1)];
        3: a = 32'h7000;  4: a = 32'h7010;  5: a = 32'h7030;
        6: a = 32'h7020 + 4 * $urandom_range(0, SEG_N - 1);
        7: a = 32'h7800;  8: a = 32'h7810;  9: a = 32'h7814;
        10: a = 32'h2000 + 4 * DMEM_WORDS;
        default: a = 32'h7020 + 4 * SEG_N;
      endcase
      addr    = a | 32'($urandom_range(0, 3));
      wren    = $urandom_range(0, 1);
      st_data = $urandom;
      st_strb = 4'($urandom);
      ld_size = 2'($urandom_range(0, 3));
      ld_uns  = $urandom_range(0, 1);
    end
    if (issued < 400) check("random_timeout", 0, 1);
    idle();
    rsp_rdy = 1;
    repeat (4) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
